// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and constants for the clock ratio meter.
// Holds the FSM state encoding, synchroniser depth and lock counter width.
package clk_ratio_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEEK,
      ST_MEAS
   } state_t;

   localparam int SYNC_STAGES = 2;
   localparam int LOCK_W      = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with a registered rising-edge pulse.
// Outputs the synchronised level and a one-cycle pulse per rising edge.
module sync_edge_det
   import clk_ratio_meter_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,
   output logic o_level,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              r_rise;

   // Shift the async input in, keep last level, register the edge pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_din};
         r_prev <= r_sync[STAGES-1];
         r_rise <= r_sync[STAGES-1] & ~r_prev;
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_rise;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period ratio and high time of clk_in against clock, with lock and stall flags.
// Optional duty check output enabled by CLK_RATIO_METER_DUTY_CHECK_EN.
module clk_ratio_meter
   import clk_ratio_meter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clk_in,
   output logic [WIDTH-1:0] ratio,
   output logic [WIDTH-1:0] high_cnt,
   output logic             meas_valid,
   output logic             locked,
   output logic             stalled
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
   ,
   output logic             duty_err
`endif
);

   localparam logic [WIDTH-1:0]  MAX      = '1;
   localparam logic [WIDTH-1:0]  ONE      = 1;
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
   localparam logic [LOCK_W-1:0] LOCK_ONE = 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_level;
   logic              w_rise;
   logic              w_clr;
   logic              w_start;
   logic              w_meas;
   logic              w_stall;
   logic [WIDTH-1:0]  w_hi_tot;
   logic [WIDTH-1:0]  r_per;
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_ratio;
   logic [WIDTH-1:0]  r_high;
   logic [WIDTH-1:0]  r_prev_ratio;
   logic              r_prev_vld;
   logic              r_mv;
   logic              r_stall;
   logic [LOCK_W-1:0] r_match;

   sync_edge_det #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_din   (clk_in),
      .o_level (w_level),
      .o_rise  (w_rise)
   );

   // The sample taken in the closing edge cycle belongs to the period.
   assign w_hi_tot = r_hi + {{(WIDTH-1){1'b0}}, w_level};

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and datapath strobes; a full counter is a stall, not a period.
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_start     = 1'b0;
      w_meas      = 1'b0;
      w_stall     = 1'b0;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
         w_clr       = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_SEEK;
            ST_SEEK: begin
               if (w_rise) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_MEAS;
               end else if (r_per == MAX) begin
                  w_stall = 1'b1;
               end
            end
            ST_MEAS: begin
               if (r_per == MAX) begin
                  w_stall     = 1'b1;
                  w_state_nxt = ST_SEEK;
               end else if (w_rise) begin
                  w_meas = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Period/high counters, result capture, stall flag and lock tracking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_per        <= '0;
         r_hi         <= '0;
         r_ratio      <= '0;
         r_high       <= '0;
         r_prev_ratio <= '0;
         r_prev_vld   <= 1'b0;
         r_mv         <= 1'b0;
         r_stall      <= 1'b0;
         r_match      <= '0;
      end else begin
         r_mv <= w_meas;
         if (w_clr) begin
            r_per      <= '0;
            r_hi       <= '0;
            r_prev_vld <= 1'b0;
            r_stall    <= 1'b0;
            r_match    <= '0;
         end else if (w_stall) begin
            r_per      <= '0;
            r_hi       <= '0;
            r_prev_vld <= 1'b0;
            r_stall    <= 1'b1;
            r_match    <= '0;
         end else if (w_start) begin
            r_per <= ONE;
            r_hi  <= '0;
         end else if (w_meas) begin
            r_ratio      <= r_per;
            r_high       <= w_hi_tot;
            r_stall      <= 1'b0;
            r_per        <= ONE;
            r_hi         <= '0;
            r_prev_ratio <= r_per;
            r_prev_vld   <= 1'b1;
            if (r_prev_vld && (r_per == r_prev_ratio)) begin
               if (r_match != LOCK_MAX) r_match <= r_match + LOCK_ONE;
            end else begin
               r_match <= '0;
            end
         end else if (r_state != ST_IDLE) begin
            r_per <= r_per + ONE;
            if ((r_state == ST_MEAS) && w_level) r_hi <= r_hi + ONE;
         end
      end
   end

   assign ratio      = r_ratio;
   assign high_cnt   = r_high;
   assign meas_valid = r_mv;
   assign locked     = (r_match == LOCK_MAX);
   assign stalled    = r_stall;

`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
   localparam logic [WIDTH:0] ONE_X = 1;

   logic [WIDTH:0] w_half_lo;
   logic [WIDTH:0] w_half_hi;
   logic           w_duty_bad;
   logic           r_duty;

   assign w_half_lo  = {1'b0, r_per} >> 1;
   assign w_half_hi  = ({1'b0, r_per} + ONE_X) >> 1;
   assign w_duty_bad = ({1'b0, w_hi_tot} != w_half_lo) &&
                       ({1'b0, w_hi_tot} != w_half_hi);

   // Duty verdict follows each measurement; leaving MEAS clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                 r_duty <= 1'b0;
      else if (w_clr || w_stall) r_duty <= 1'b0;
      else if (w_meas)           r_duty <= w_duty_bad;
   end

   assign duty_err = r_duty;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed self-checking bench for clk_ratio_meter.
// Duty checks are compiled in with CLK_RATIO_METER_DUTY_CHECK_EN.
module tb_clk_ratio_meter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       clk_in = 1'b0;
   logic [7:0] ratio;
   logic [7:0] high_cnt;
   logic       meas_valid;
   logic       locked;
   logic       stalled;
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
   logic       duty_err;
`endif

   int checks = 0;
   int errors = 0;

   // clk_in generator, in half-cycles of clock; new settings take effect at a rise
   int g_n = 8;
   int g_h = 4;
   int cur_n = 8;
   int cur_h = 4;
   int ph = 0;
   bit g_on = 1'b0;

   always #5 clock = ~clock;

   clk_ratio_meter #(
      .WIDTH    (8),
      .LOCK_CNT (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .clk_in     (clk_in),
      .ratio      (ratio),
      .high_cnt   (high_cnt),
      .meas_valid (meas_valid),
      .locked     (locked),
      .stalled    (stalled)
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
      ,
      .duty_err   (duty_err)
`endif
   );

   initial begin
      forever begin
         @(posedge clock or negedge clock);
         #1;
         if (!g_on) begin
            clk_in = 1'b0;
            ph = 0;
         end else begin
            if (ph == 0) begin
               cur_n = g_n;
               cur_h = g_h;
            end
            clk_in = (ph < cur_h);
            ph = (ph + 1 >= cur_n) ? 0 : ph + 1;
         end
      end
   end

   task automatic wait_mv(input int budget, output bit got, output int cyc);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < budget) begin
         @(posedge clock);
         #2;
         cyc++;
         if (meas_valid) got = 1'b1;
      end
   endtask

   task automatic restart(input int n, input int h);
      enable = 1'b0;
      g_n = n;
      g_h = h;
      g_on = 1'b1;
      repeat (40) @(posedge clock);
      #2;
      enable = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #2;
      checks++;
      if (ratio !== 8'd0) begin
         errors++; $display("FAIL reset_ratio got %0d want 0", ratio);
      end
      checks++;
      if (high_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_high got %0d want 0", high_cnt);
      end
      checks++;
      if ({meas_valid, locked, stalled} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b want 000", {meas_valid, locked, stalled});
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_div4();
      bit got;
      int cyc;
      logic exp_lock;
      restart(8, 4);
      for (int i = 1; i <= 6; i++) begin
         wait_mv(30, got, cyc);
         exp_lock = (i >= 5);
         checks++;
         if (!got) begin
            errors++; $display("FAIL div4_timeout meas %0d got none want meas_valid", i);
         end
         checks++;
         if (ratio !== 8'd4) begin
            errors++; $display("FAIL div4_ratio meas %0d got %0d want 4", i, ratio);
         end
         checks++;
         if (high_cnt !== 8'd2) begin
            errors++; $display("FAIL div4_high meas %0d got %0d want 2", i, high_cnt);
         end
         checks++;
         if (locked !== exp_lock) begin
            errors++; $display("FAIL div4_lock meas %0d got %b want %b", i, locked, exp_lock);
         end
         if (i >= 2) begin
            checks++;
            if (cyc !== 4) begin
               errors++; $display("FAIL div4_interval meas %0d got %0d want 4", i, cyc);
            end
         end
      end
   endtask

   task automatic test_div5();
      bit got;
      int cyc;
      logic exp_lock;
      restart(10, 5);
      for (int i = 1; i <= 5; i++) begin
         wait_mv(30, got, cyc);
         exp_lock = (i >= 5);
         checks++;
         if (!got || ratio !== 8'd5) begin
            errors++; $display("FAIL div5_ratio meas %0d got %0d want 5", i, ratio);
         end
         checks++;
         if (high_cnt !== 8'd2 && high_cnt !== 8'd3) begin
            errors++; $display("FAIL div5_high meas %0d got %0d want 2 or 3", i, high_cnt);
         end
         checks++;
         if (locked !== exp_lock) begin
            errors++; $display("FAIL div5_lock meas %0d got %b want %b", i, locked, exp_lock);
         end
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
         checks++;
         if (duty_err !== 1'b0) begin
            errors++; $display("FAIL div5_duty meas %0d got %b want 0", i, duty_err);
         end
`endif
      end
   endtask

   task automatic test_ratio_change();
      bit got;
      int cyc;
      logic exp_lock;
      restart(8, 4);
      repeat (5) wait_mv(30, got, cyc);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL chg_prelock got %b want 1", locked);
      end
      g_n = 12;
      g_h = 6;
      for (int k = 0; k < 3; k++) begin
         wait_mv(30, got, cyc);
         if (ratio !== 8'd4) break;
      end
      checks++;
      if (ratio !== 8'd6) begin
         errors++; $display("FAIL chg_first_ratio got %0d want 6", ratio);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL chg_first_lock got %b want 0", locked);
      end
      for (int i = 1; i <= 4; i++) begin
         wait_mv(30, got, cyc);
         exp_lock = (i == 4);
         checks++;
         if (!got || ratio !== 8'd6) begin
            errors++; $display("FAIL chg_ratio meas %0d got %0d want 6", i, ratio);
         end
         checks++;
         if (locked !== exp_lock) begin
            errors++; $display("FAIL chg_lock meas %0d got %b want %b", i, locked, exp_lock);
         end
      end
   endtask

   task automatic test_stall();
      bit got;
      int cyc;
      int mv_seen;
      wait_mv(30, got, cyc);
      g_on = 1'b0;
      mv_seen = 0;
      repeat (300) begin
         @(posedge clock);
         #2;
         if (meas_valid) mv_seen++;
      end
      checks++;
      if (mv_seen !== 0) begin
         errors++; $display("FAIL stall_no_meas got %0d want 0", mv_seen);
      end
      checks++;
      if (stalled !== 1'b1) begin
         errors++; $display("FAIL stall_flag got %b want 1", stalled);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL stall_lock got %b want 0", locked);
      end
      checks++;
      if (ratio !== 8'd6 || high_cnt !== 8'd3) begin
         errors++; $display("FAIL stall_hold got %0d/%0d want 6/3", ratio, high_cnt);
      end
      g_n = 6;
      g_h = 3;
      g_on = 1'b1;
      wait_mv(40, got, cyc);
      checks++;
      if (!got || ratio !== 8'd3) begin
         errors++; $display("FAIL stall_resume_ratio got %0d want 3", ratio);
      end
      checks++;
      if (stalled !== 1'b0) begin
         errors++; $display("FAIL stall_resume_flag got %b want 0", stalled);
      end
   endtask

   task automatic test_enable();
      bit got;
      int cyc;
      int mv_seen;
      repeat (5) wait_mv(30, got, cyc);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL en_prelock got %b want 1", locked);
      end
      @(posedge clock);
      #2;
      enable = 1'b0;
      @(posedge clock);
      #2;
      checks++;
      if ({locked, stalled, meas_valid} !== 3'b000) begin
         errors++; $display("FAIL en_off_flags got %b want 000", {locked, stalled, meas_valid});
      end
      checks++;
      if (ratio !== 8'd3) begin
         errors++; $display("FAIL en_off_ratio got %0d want 3", ratio);
      end
      mv_seen = 0;
      repeat (20) begin
         @(posedge clock);
         #2;
         if (meas_valid) mv_seen++;
      end
      checks++;
      if (mv_seen !== 0) begin
         errors++; $display("FAIL en_off_quiet got %0d want 0", mv_seen);
      end
   endtask

   task automatic test_reset_async();
      bit got;
      int cyc;
      restart(16, 8);
      repeat (2) wait_mv(30, got, cyc);
      checks++;
      if (ratio !== 8'd8 || high_cnt !== 8'd4) begin
         errors++; $display("FAIL rst_pre got %0d/%0d want 8/4", ratio, high_cnt);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (ratio !== 8'd0 || high_cnt !== 8'd0) begin
         errors++; $display("FAIL rst_async_vals got %0d/%0d want 0/0", ratio, high_cnt);
      end
      checks++;
      if ({meas_valid, locked, stalled} !== 3'b000) begin
         errors++; $display("FAIL rst_async_flags got %b want 000", {meas_valid, locked, stalled});
      end
      #1;
      reset = 1'b0;
      wait_mv(40, got, cyc);
      checks++;
      if (!got || ratio !== 8'd8 || high_cnt !== 8'd4) begin
         errors++; $display("FAIL rst_first_meas got %0d/%0d want 8/4", ratio, high_cnt);
      end
   endtask

   task automatic test_ratio2();
      bit got;
      int cyc;
      restart(4, 2);
      for (int i = 1; i <= 3; i++) begin
         wait_mv(30, got, cyc);
         checks++;
         if (!got || ratio !== 8'd2 || high_cnt !== 8'd1) begin
            errors++; $display("FAIL div2 meas %0d got %0d/%0d want 2/1", i, ratio, high_cnt);
         end
         if (i >= 2) begin
            checks++;
            if (cyc !== 2) begin
               errors++; $display("FAIL div2_interval meas %0d got %0d want 2", i, cyc);
            end
         end
      end
   endtask

   task automatic test_duty();
      bit got;
      int cyc;
      restart(16, 4);
      for (int i = 1; i <= 3; i++) begin
         wait_mv(30, got, cyc);
         checks++;
         if (!got || ratio !== 8'd8 || high_cnt !== 8'd2) begin
            errors++; $display("FAIL div8_25 meas %0d got %0d/%0d want 8/2", i, ratio, high_cnt);
         end
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
         checks++;
         if (duty_err !== 1'b1) begin
            errors++; $display("FAIL duty_set meas %0d got %b want 1", i, duty_err);
         end
`endif
      end
      enable = 1'b0;
      @(posedge clock);
      #2;
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
      checks++;
      if (duty_err !== 1'b0) begin
         errors++; $display("FAIL duty_clear got %b want 0", duty_err);
      end
`endif
      checks++;
      if (ratio !== 8'd8 || locked !== 1'b0) begin
         errors++; $display("FAIL duty_off got %0d/%b want 8/0", ratio, locked);
      end
   endtask

   initial begin
      test_reset();
      test_div4();
      test_div5();
      test_ratio_change();
      test_stall();
      test_enable();
      test_reset_async();
      test_ratio2();
      test_duty();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
